// File: rtl/axis_packetizer.sv
// ---------------------------------------------------------------------------
// axis_packetizer
//   Frames a raw valid/ready word stream into AXI4-Stream packets. A packet
//   closes (tlast) after PKT_LEN words, after TIMEOUT idle cycles with a word
//   pending, or when in_flush is seen. One word is held back in H so tlast can
//   be placed on the true last word without look-ahead from the source.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   in_data/in_valid     raw word stream; accepted when in_valid & in_ready
//   in_ready             raw word may be taken this cycle
//   in_flush             level; closes the current partial packet
//   tdata/tkeep/tid/     AXI4-Stream master side; tkeep is all ones while
//   tdest/tuser/tlast/   tvalid, tid/tdest carry STREAM_ID, tuser marks the
//   tvalid/tready        first word of a packet
//   pkt_cnt              count of tlast handshakes, wraps at 16 bits
// ---------------------------------------------------------------------------
module axis_packetizer #(
    parameter int DATA_W    = 32,
    parameter int ID_W      = 8,
    parameter int PKT_LEN   = 16,
    parameter int TIMEOUT   = 256,
    parameter int STREAM_ID = 0
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_flush,
    output logic [DATA_W-1:0]   tdata,
    output logic [DATA_W/8-1:0] tkeep,
    output logic [ID_W-1:0]     tid,
    output logic [ID_W-1:0]     tdest,
    output logic                tuser,
    output logic                tlast,
    output logic                tvalid,
    input  logic                tready,
    output logic [15:0]         pkt_cnt
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    // Timer value from which the next idle cycle completes the timeout.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Hold register H
    logic              h_v;
    logic [DATA_W-1:0] h_data;
    logic [IDX_W-1:0]  h_idx;

    logic [TMR_W-1:0]  timer;
    logic              to_flag;

    logic              o_free;
    logic              in_acc;
    logic              h_at_end;
    logic              move;
    logic [IDX_W-1:0]  new_idx;

    always_comb begin
        o_free   = ~tvalid | tready;
        in_ready = ~h_v | o_free;
        in_acc   = in_valid & in_ready;
        h_at_end = (h_idx == LAST_IDX);
        move     = h_v & o_free & (in_acc | h_at_end | to_flag | in_flush);
        // H only empties through a move with tlast set, so a word landing in an
        // empty H always opens a new packet. A word accepted while H is full
        // forces a move, and that moved word closed the packet iff it sat at
        // the last index.
        // NOTE: every combinational output gets a value on every path; a
        // missing assignment here would infer a latch.
        new_idx  = '0;
        if (h_v && !h_at_end)
            new_idx = h_idx + IDX_W'(1);
    end

    assign tkeep = {(DATA_W/8){tvalid}};
    assign tid   = ID_W'(STREAM_ID);
    assign tdest = ID_W'(STREAM_ID);

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            h_v   <= 1'b0;
            h_idx <= '0;
        end else if (in_acc) begin
            h_v   <= 1'b1;
            h_idx <= new_idx;
        end else if (move) begin
            h_v   <= 1'b0;
        end
    end

    // NOTE: the held data word carries no reset; it is only observed while
    // h_v is set, which is reset, so the data flops can stay reset-free.
    always_ff @(posedge clk) begin
        if (in_acc)
            h_data <= in_data;
    end

    // Output register O. Payload fields only change on a move, which requires
    // o_free, so they stay stable while tvalid waits for tready.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
        end else if (move) begin
            tvalid <= 1'b1;
            tdata  <= h_data;
            tuser  <= (h_idx == '0);
            // A successor arriving in the same cycle means the packet goes on,
            // even if a timeout or flush is also pending.
            tlast  <= h_at_end | ~in_acc;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

    // Idle timer: runs while a word waits in H with nothing new arriving.
    // to_flag is sticky until the held word is moved out.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            timer   <= '0;
            to_flag <= 1'b0;
        end else begin
            if (in_acc || !h_v || move)
                timer <= '0;
            else if (TIMEOUT != 0 && !to_flag)
                timer <= timer + TMR_W'(1);

            if (move)
                to_flag <= 1'b0;
            else if (TIMEOUT != 0 && h_v && !in_acc && !to_flag && timer == TMR_LAST)
                to_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            pkt_cnt <= '0;
        else if (tvalid && tready && tlast)
            pkt_cnt <= pkt_cnt + 16'd1;
    end

endmodule
